// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters / data memory and mem_arbiter.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester commands
//   ack0/ack1                                      : one-cycle completion pulses
//   rdata                                          : data of last completed read
//   mem_read, mem_write, mem_addr, mem_wdata       : memory command
//   mem_rdata                                      : memory read data
// Modports: slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if;
  logic        req0;
  logic        we0;
  logic [9:0]  addr0;
  logic [31:0] wdata0;
  logic        ack0;
  logic        req1;
  logic        we1;
  logic [9:0]  addr1;
  logic [31:0] wdata1;
  logic        ack1;
  logic [31:0] rdata;
  logic        mem_read;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, ack1, rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, ack1, rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single-ported data
// memory. One access at a time: the winner's command is held on mem_* for
// MEM_LAT cycles, read data is captured on the last of them, and the winner
// gets a one-cycle ack.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : mem_arbiter_if.slave (requester commands/acks, rdata, memory bus)
//   gnt_cnt0/gnt_cnt1 : saturating per-port grant counters, present only when
//                       MEM_ARB_STATS_EN is defined
// Parameters: MEM_LAT (1..15) command hold cycles, CNT_W latency counter width
// (2**CNT_W > MEM_LAT).
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              rr_ptr, rr_d;
  logic              gnt_id, gnt_d;
  logic              win1;
  logic              ack0_d, ack1_d;
  logic              rd_d, wr_d;
  logic [9:0]        addr_d;
  logic [31:0]       wdata_d, rdata_d;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= 1'b0;
      gnt_id        <= 1'b0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rdata     <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      rr_ptr        <= rr_d;
      gnt_id        <= gnt_d;
      bus.ack0      <= ack0_d;
      bus.ack1      <= ack1_d;
      bus.mem_read  <= rd_d;
      bus.mem_write <= wr_d;
      bus.mem_addr  <= addr_d;
      bus.mem_wdata <= wdata_d;
      bus.rdata     <= rdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rr_d    = rr_ptr;
    gnt_d   = gnt_id;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd_d    = bus.mem_read;
    wr_d    = bus.mem_write;
    addr_d  = bus.mem_addr;
    wdata_d = bus.mem_wdata;
    rdata_d = bus.rdata;
    // Port 1 wins when it is the only requester, or on contention when favoured
    win1    = bus.req1 & (~bus.req0 | rr_ptr);

    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          gnt_d   = win1;
          rd_d    = win1 ? ~bus.we1 : ~bus.we0;
          wr_d    = win1 ? bus.we1 : bus.we0;
          addr_d  = win1 ? bus.addr1 : bus.addr0;
          wdata_d = win1 ? bus.wdata1 : bus.wdata0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(MEM_LAT - 1)) begin
          if (bus.mem_read) begin
            rdata_d = bus.mem_rdata;
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack0_d  = ~gnt_id;
          ack1_d  = gnt_id;
          rr_d    = ~gnt_id;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  // Saturating grant counters, bumped on the edge that raises the port's ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (ack0_d && (gnt_cnt0 != 16'hFFFF)) begin
        gnt_cnt0 <= gnt_cnt0 + 16'd1;
      end
      if (ack1_d && (gnt_cnt1 != 16'hFFFF)) begin
        gnt_cnt1 <= gnt_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported data memory (1 KB byte address, 32-bit words, fixed access delay).
- Accepts read/write requests from two clients (e.g. fetch and load/store), grants one at a time with round-robin fairness, and holds the memory command stable for MEM_LAT cycles.
- Returns read data with a one-cycle ack pulse to the winning requester.

Parameters:
- MEM_LAT, 2, cycles the memory command is held before read data is captured; legal range 1..15.
- CNT_W, 4, width of the internal latency counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 access request, level
- we0  in  1  requester 0: 1=write, 0=read
- addr0  in  10  requester 0 byte address
- wdata0  in  32  requester 0 write data
- ack0  out  1  requester 0 completion, one-cycle pulse
- req1, we1, addr1, wdata1, ack1  same as port 0 for requester 1
- rdata  out  32  read data of the most recently completed read; valid in the ack cycle and held afterwards
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  10  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0, rr_ptr=0 (favour port 0), ack0=ack1=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, rdata=0. Reset mid-transaction aborts it. No ack is issued and the memory strobes drop immediately.
- States: IDLE, BUSY, DONE.
- IDLE: at a rising edge, if req0|req1, select the winner:
  - Only one request is high: that port wins.
  - Both are high: the port equal to rr_ptr wins.
  - Latch the winner's we/addr/wdata into mem_* (mem_write=we, mem_read=~we), record gnt_id, cnt=0, go to BUSY.
  - No request: stay in IDLE, strobes 0.
- BUSY: mem_* held constant. cnt increments each cycle. When cnt==MEM_LAT-1:
  - if read, capture mem_rdata into rdata;
  - drive strobes to 0, assert ack[gnt_id]=1, set rr_ptr=~gnt_id, go to DONE.
- DONE: ack high for exactly this cycle. No new request is sampled. Next state is IDLE.
- Latency: request sampled at edge E, so the strobes are high in cycles E+1..E+MEM_LAT and ack is high in cycle E+MEM_LAT+1. Peak throughput is one access per MEM_LAT+2 cycles.
- Writes leave rdata unchanged.
- Requester protocol: hold req and its fields stable until ack. Deassert req in the ack cycle, or it is treated as a new request at the next IDLE edge.
- If req drops while BUSY, the transaction still completes and ack still pulses.
- addr[1:0] passes through unmodified; the memory ignores it.
- Fairness: after a grant to port N, a simultaneous request pair is granted to port ~N. Under continuous contention the ports alternate strictly.
- ack0 and ack1 are never high together. mem_read and mem_write are never high together.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each).
  - Each counter increments by 1 in its port's ack cycle.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single read, MEM_LAT=2, memory preloaded word i=i: req0=1, we0=0, addr0=10'h014 sampled at edge E -> mem_read high in cycles E+1..E+2, mem_addr=10'h014, ack0 high in cycle E+3 only, rdata=32'd5.
- Write then read: port1 writes 32'hDEADBEEF to 10'h020, then port1 reads 10'h020 -> first ack1 with rdata unchanged, second ack1 with rdata=32'hDEADBEEF. mem_write is never high during the read.
- Contention: req0 and req1 held high for 4 transactions after reset -> grant order 0,1,0,1. ack0/ack1 never overlap. Each transaction spans MEM_LAT+2 cycles.
- Request withdrawn: req0 pulsed for one cycle, then low -> transaction completes and ack0 still pulses at E+MEM_LAT+1.
- Reset mid-BUSY: assert reset_n=0 asynchronously in cycle E+1 -> mem_read=0 and ack0=0 immediately, rdata=0, state IDLE. After release, a simultaneous req0/req1 grants port 0.
- With MEM_ARB_STATS_EN defined: 3 port-0 and 2 port-1 accesses -> gnt_cnt0=3, gnt_cnt1=2. Both counters read 0 after reset.
